// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states
// and size decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_e;

    // Low two funct3 bits carry the access size in log2 bytes.
    function automatic logic [3:0] size_bytes(input logic [1:0] size_code);
        logic [3:0] bytes;
        case (size_code)
            2'b00:   bytes = 4'd1;
            2'b01:   bytes = 4'd2;
            2'b10:   bytes = 4'd4;
            default: bytes = 4'd8;
        endcase
        return bytes;
    endfunction

    function automatic logic size_legal(input logic [2:0] funct3, input logic is_write,
                                        input logic wide);
        logic legal;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_D:             legal = wide;
            F3_BU, F3_HU:     legal = ~is_write;
            F3_WU:            legal = wide & ~is_write;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store data/strobe shifting across two beats and
// load extraction with sign or zero extension.
module load_store_unit_align #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [$clog2(DATA_WIDTH/8)-1:0] off,
    input  logic [3:0]                      size,
    input  logic                            is_signed,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [DATA_WIDTH-1:0]           lo_data,
    input  logic [DATA_WIDTH-1:0]           hi_data,
    output logic [DATA_WIDTH-1:0]           st_lo,
    output logic [DATA_WIDTH-1:0]           st_hi,
    output logic [DATA_WIDTH/8-1:0]         strb_lo,
    output logic [DATA_WIDTH/8-1:0]         strb_hi,
    output logic [DATA_WIDTH-1:0]           ld_result
);
    localparam int NB = DATA_WIDTH / 8;

    logic [2*NB-1:0]         size_mask_s;
    logic [2*NB-1:0]         strb_wide_s;
    logic [DATA_WIDTH-1:0]   lane_mask_s;
    logic [2*DATA_WIDTH-1:0] st_wide_s;
    logic [DATA_WIDTH-1:0]   ld_raw_s;
    logic                    sign_bit_s;

    // Shift the sized store into a double-width window; low half is beat 1.
    always_comb begin
        size_mask_s = ({{(2*NB-1){1'b0}}, 1'b1} << size) - {{(2*NB-1){1'b0}}, 1'b1};
        for (int i = 0; i < NB; i++) begin
            lane_mask_s[8*i +: 8] = {8{size_mask_s[i]}};
        end
        strb_wide_s = size_mask_s << off;
        st_wide_s   = {{DATA_WIDTH{1'b0}}, wdata & lane_mask_s} << {off, 3'b000};
        st_lo       = st_wide_s[DATA_WIDTH-1:0];
        st_hi       = st_wide_s[2*DATA_WIDTH-1:DATA_WIDTH];
        strb_lo     = strb_wide_s[NB-1:0];
        strb_hi     = strb_wide_s[2*NB-1:NB];
    end

    // Extract the addressed bytes from {hi,lo} and extend to full width.
    always_comb begin
        ld_raw_s = DATA_WIDTH'({hi_data, lo_data} >> {off, 3'b000});
        case (size)
            4'd1:    sign_bit_s = ld_raw_s[7];
            4'd2:    sign_bit_s = ld_raw_s[15];
            4'd4:    sign_bit_s = ld_raw_s[31];
            default: sign_bit_s = ld_raw_s[DATA_WIDTH-1];
        endcase
        ld_result = (ld_raw_s & lane_mask_s) |
                    ((is_signed & sign_bit_s) ? ~lane_mask_s : {DATA_WIDTH{1'b0}});
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit between control path and memory bus.
// Define UNALIGNED_EN to split unaligned accesses into two aligned beats.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_response
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
`ifdef UNALIGNED_EN
    localparam logic SPLIT_OK = 1'b1;
`else
    localparam logic SPLIT_OK = 1'b0;
`endif

    lsu_state_e state_r, next_state_s;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [OFF_W-1:0]      off_r;
    logic [3:0]            size_r;
    logic                  signed_r;
    logic                  write_r;
    logic [DATA_WIDTH-1:0] wdata_r;
`ifdef UNALIGNED_EN
    logic                  split_r;
    logic [DATA_WIDTH-1:0] lo_r;
`endif

    logic [OFF_W-1:0]      req_off_s;
    logic [ADDR_WIDTH-1:0] req_base_s;
    logic [3:0]            req_size_s;
    logic                  req_legal_s;
    logic                  req_split_s;
    logic                  accept_s;

    logic [OFF_W-1:0]      al_off_s;
    logic [3:0]            al_size_s;
    logic                  al_signed_s;
    logic [DATA_WIDTH-1:0] al_wdata_s, al_lo_s, al_hi_s;
    logic [DATA_WIDTH-1:0] st_lo_s, st_hi_s, ld_result_s;
    logic [NB-1:0]         strb_lo_s, strb_hi_s;

    logic                  beat1_s, beat2_s, bus_write_s;
    logic [ADDR_WIDTH-1:0] bus_base_s;
    logic                  nx_read_s, nx_write_s, nx_resp_valid_s, nx_resp_err_s;
    logic [ADDR_WIDTH-1:0] nx_addr_s;
    logic [DATA_WIDTH-1:0] nx_wdata_s, nx_rdata_s;
    logic [NB-1:0]         nx_wstrb_s;

    // Decode the incoming request: lane offset, size, legality and split.
    always_comb begin
        req_off_s   = req_addr[OFF_W-1:0];
        req_base_s  = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        req_size_s  = size_bytes(req_funct3[1:0]);
        req_legal_s = size_legal(req_funct3, req_write, DATA_WIDTH == 64);
        req_split_s = (5'(req_off_s) + 5'(req_size_s)) > 5'(NB);
        accept_s    = (state_r == ST_IDLE) & req_valid;
    end

    // Lane logic sees the live request in IDLE so beat 1 can launch on acceptance.
    always_comb begin
        if (state_r == ST_IDLE) begin
            al_off_s    = req_off_s;
            al_size_s   = req_size_s;
            al_signed_s = ~req_funct3[2];
            al_wdata_s  = req_wdata;
            bus_write_s = req_write;
            bus_base_s  = req_base_s;
        end else begin
            al_off_s    = off_r;
            al_size_s   = size_r;
            al_signed_s = signed_r;
            al_wdata_s  = wdata_r;
            bus_write_s = write_r;
            bus_base_s  = addr_r;
        end
    end

`ifdef UNALIGNED_EN
    assign al_lo_s = (state_r == ST_BEAT2) ? lo_r : mem_rdata;
    assign al_hi_s = mem_rdata;
`else
    assign al_lo_s = mem_rdata;
    assign al_hi_s = {DATA_WIDTH{1'b0}};
`endif

    load_store_unit_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .off       (al_off_s),
        .size      (al_size_s),
        .is_signed (al_signed_s),
        .wdata     (al_wdata_s),
        .lo_data   (al_lo_s),
        .hi_data   (al_hi_s),
        .st_lo     (st_lo_s),
        .st_hi     (st_hi_s),
        .strb_lo   (strb_lo_s),
        .strb_hi   (strb_hi_s),
        .ld_result (ld_result_s)
    );

    // Next state; the final beat's data is extended as it arrives so DONE is registered.
    always_comb begin
        next_state_s    = state_r;
        beat1_s         = 1'b0;
        beat2_s         = 1'b0;
        nx_resp_valid_s = 1'b0;
        nx_resp_err_s   = 1'b0;
        nx_rdata_s      = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (req_valid && (!req_legal_s || (req_split_s && !SPLIT_OK))) begin
                    next_state_s    = ST_DONE;
                    nx_resp_valid_s = 1'b1;
                    nx_resp_err_s   = 1'b1;
                end else if (req_valid) begin
                    next_state_s = ST_BEAT1;
                    beat1_s      = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BEAT1: begin
                if (!mem_response) begin
                    next_state_s = ST_BEAT1;
                    beat1_s      = 1'b1;
`ifdef UNALIGNED_EN
                end else if (split_r) begin
                    next_state_s = ST_BEAT2;
                    beat2_s      = 1'b1;
`endif
                end else begin
                    next_state_s    = ST_DONE;
                    nx_resp_valid_s = 1'b1;
                    nx_rdata_s      = write_r ? {DATA_WIDTH{1'b0}} : ld_result_s;
                end
            end
`ifdef UNALIGNED_EN
            ST_BEAT2: begin
                if (!mem_response) begin
                    next_state_s = ST_BEAT2;
                    beat2_s      = 1'b1;
                end else begin
                    next_state_s    = ST_DONE;
                    nx_resp_valid_s = 1'b1;
                    nx_rdata_s      = write_r ? {DATA_WIDTH{1'b0}} : ld_result_s;
                end
            end
`endif
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Bus request for the beat entered on the next edge; the second beat wraps the address.
    always_comb begin
        nx_read_s  = (beat1_s | beat2_s) & ~bus_write_s;
        nx_write_s = (beat1_s | beat2_s) & bus_write_s;
        nx_addr_s  = beat2_s ? (bus_base_s + ADDR_WIDTH'(NB)) :
                     (beat1_s ? bus_base_s : {ADDR_WIDTH{1'b0}});
        nx_wdata_s = !nx_write_s ? {DATA_WIDTH{1'b0}} : (beat2_s ? st_hi_s : st_lo_s);
        nx_wstrb_s = !nx_write_s ? {NB{1'b0}} : (beat2_s ? strb_hi_s : strb_lo_s);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= {DATA_WIDTH{1'b0}};
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= {ADDR_WIDTH{1'b0}};
            mem_wdata  <= {DATA_WIDTH{1'b0}};
            mem_wstrb  <= {NB{1'b0}};
        end else begin
            state_r    <= next_state_s;
            req_ready  <= (next_state_s == ST_IDLE);
            resp_valid <= nx_resp_valid_s;
            resp_err   <= nx_resp_err_s;
            resp_rdata <= nx_rdata_s;
            mem_read   <= nx_read_s;
            mem_write  <= nx_write_s;
            mem_addr   <= nx_addr_s;
            mem_wdata  <= nx_wdata_s;
            mem_wstrb  <= nx_wstrb_s;
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r   <= {ADDR_WIDTH{1'b0}};
            off_r    <= {OFF_W{1'b0}};
            size_r   <= 4'd0;
            signed_r <= 1'b0;
            write_r  <= 1'b0;
            wdata_r  <= {DATA_WIDTH{1'b0}};
`ifdef UNALIGNED_EN
            split_r  <= 1'b0;
`endif
        end else if (accept_s) begin
            addr_r   <= req_base_s;
            off_r    <= req_off_s;
            size_r   <= req_size_s;
            signed_r <= ~req_funct3[2];
            write_r  <= req_write;
            wdata_r  <= req_wdata;
`ifdef UNALIGNED_EN
            split_r  <= req_split_s;
`endif
        end else begin
            addr_r   <= addr_r;
        end
    end

`ifdef UNALIGNED_EN
    // Low half of a split load, held for the second beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_r <= {DATA_WIDTH{1'b0}};
        end else if (state_r == ST_BEAT1 && mem_response) begin
            lo_r <= mem_rdata;
        end else begin
            lo_r <= lo_r;
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit at DATA_WIDTH 32 with a
// zero-wait bus slave; split cases follow whether UNALIGNED_EN is defined.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write, mem_response;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    resp_t       sb_q[$];
    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    int          n_compared = 0;
    int          n_mismatched = 0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_response(mem_response)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_wbeat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        beat_q.push_back('{1'b1, a, d, s});
    endtask

    task automatic exp_rbeat(input logic [31:0] a, input logic [31:0] rdata);
        beat_q.push_back('{1'b0, a, 32'h0, 4'h0});
        rd_q.push_back(rdata);
    endtask

    // One request through a zero-wait slave; bus beats and response go against the queues.
    task automatic do_access(input string tag, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        resp_t r;
        beat_t b;
        int    cyc;
        bit    got;
        @(negedge clk);
        check({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        sb_q.push_back('{exp_rd, exp_err, exp_lat});
        @(posedge clk);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            mem_response = 1'b0;
            check({tag, "_rw_excl"}, mem_read & mem_write, 0);
            if (resp_valid) begin
                got = 1'b1;
                r = sb_q.pop_front();
                check({tag, "_rdata"}, resp_rdata, r.rdata);
                check({tag, "_err"}, resp_err, r.err);
                check({tag, "_latency"}, cyc, r.lat);
                check({tag, "_ready_done"}, req_ready, 0);
            end else if (mem_read || mem_write) begin
                mem_response = 1'b1;
                mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
                if (beat_q.size() == 0) begin
                    check({tag, "_extra_beat"}, 1, 0);
                end else begin
                    b = beat_q.pop_front();
                    check({tag, "_beat_wr"}, mem_write, b.wr);
                    check({tag, "_beat_addr"}, mem_addr, b.addr);
                    check({tag, "_beat_strb"}, mem_wstrb, b.strb);
                    if (b.wr) check({tag, "_beat_wdata"}, mem_wdata, b.wdata);
                end
            end
        end
        mem_response = 1'b0;
        if (!got) check({tag, "_timeout"}, 0, 1);
        check({tag, "_beats_left"}, beat_q.size(), 0);
        beat_q.delete();
        rd_q.delete();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_response = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_resp", {resp_valid, resp_err}, 0);
        check("rst_mem_rw", {mem_read, mem_write}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        check("rst_rdata", resp_rdata, 0);
        reset = 1'b0;

        exp_wbeat(32'h100, 32'hDEADBEEF, 4'b1111);
        do_access("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        exp_rbeat(32'h100, 32'h80112233);
        do_access("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        exp_rbeat(32'h100, 32'h80112233);
        do_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h00000080, 1'b0, 2);
        exp_rbeat(32'h100, 32'h80112233);
        do_access("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8011, 1'b0, 2);
        exp_rbeat(32'h000, 32'h12348765);
        do_access("lhu", 1'b0, 3'b101, 32'h000, 32'h0, 32'h00008765, 1'b0, 2);
        exp_wbeat(32'h100, 32'h00005A00, 4'b0010);
        do_access("sb", 1'b1, 3'b000, 32'h101, 32'hFFFFFF5A, 32'h0, 1'b0, 2);

`ifdef UNALIGNED_EN
        exp_rbeat(32'h100, 32'hAABBCCDD);
        exp_rbeat(32'h104, 32'h11223344);
        do_access("lw_split", 1'b0, 3'b010, 32'h102, 32'h0, 32'h3344AABB, 1'b0, 3);
        exp_wbeat(32'h100, 32'hEF000000, 4'b1000);
        exp_wbeat(32'h104, 32'h000000BE, 4'b0001);
        do_access("sh_split", 1'b1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0, 1'b0, 3);
        exp_rbeat(32'hFFFFFFFC, 32'h7F000000);
        exp_rbeat(32'h00000000, 32'h000000FF);
        do_access("lh_wrap", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'hFFFFFF7F, 1'b0, 3);
`else
        do_access("lw_misal", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1);
        do_access("sh_misal", 1'b1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0, 1'b1, 1);
        do_access("lh_misal", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1);
`endif
        do_access("ld_32", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1);
        do_access("sbu_ill", 1'b1, 3'b100, 32'h100, 32'h12345678, 32'h0, 1'b1, 1);
        do_access("f3_111", 1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1, 1);

        // Abort an access stalled in the first beat.
        @(negedge clk);
        check("abort_ready_pre", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_c1_read", mem_read, 1);
        @(negedge clk);
        check("abort_c2_read", mem_read, 1);
        @(negedge clk);
        check("abort_c3_read", mem_read, 1);
        check("abort_c3_ready", req_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_c4_read", mem_read, 0);
        check("abort_c4_ready", req_ready, 1);
        check("abort_c4_resp", resp_valid, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_resp", resp_valid, 0);
            check("abort_no_bus", {mem_read, mem_write}, 0);
        end

        exp_rbeat(32'h200, 32'hCAFEF00D);
        do_access("lw_recover", 1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        check("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
